// File: rtl/fp_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fp_pkg : FSM states, flag bit indices and format helper functions    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package fp_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_UNPACK = 3'd1,
      ST_MUL    = 3'd2,
      ST_NORM   = 3'd3,
      ST_ROUND  = 3'd4,
      ST_DONE   = 3'd5
   } fp_state_t;

   localparam int FLG_INEXACT   = 0;
   localparam int FLG_UNDERFLOW = 1;
   localparam int FLG_OVERFLOW  = 2;
   localparam int FLG_INVALID   = 3;

   function automatic int fp_bias(input int exp_w);
      return (1 << (exp_w - 1)) - 1;
   endfunction

   // Quiet NaN: positive, all-ones exponent, only the fraction MSB set.
   function automatic logic [63:0] fp_qnan(input int exp_w, input int man_w);
      logic [63:0] exp_ones;
      exp_ones = (64'd1 << exp_w) - 64'd1;
      return (exp_ones << man_w) | (64'd1 << (man_w - 1));
   endfunction

endpackage
`default_nettype wire

// File: rtl/fp_mant_mul_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fp_mant_mul_seq : radix-2 shift-add significand multiplier           |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module fp_mant_mul_seq
   import fp_pkg::*;
#(
   parameter int MAN_W = 23
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 load,
   input  logic                 step,
   input  logic [MAN_W:0]       mcand,
   input  logic [MAN_W:0]       mplier,
   output logic [2*MAN_W+1:0]   product
);

   localparam int M = MAN_W + 1;

   logic [2*M-1:0] prod_q, prod_d;
   logic [M-1:0]   mcand_q, mcand_d;
   logic [M:0]     w_sum;

   // Multiplier sits in the low half and is consumed LSB first while the
   // partial sum shifts in from the top; M steps leave the full product.
   always_comb begin
      prod_d  = prod_q;
      mcand_d = mcand_q;
      w_sum   = {1'b0, prod_q[2*M-1:M]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
      if (load) begin
         prod_d  = {{M{1'b0}}, mplier};
         mcand_d = mcand;
      end else if (step) begin
         prod_d  = {w_sum, prod_q[M-1:1]};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prod_q  <= '0;
         mcand_q <= '0;
      end else begin
         prod_q  <= prod_d;
         mcand_q <= mcand_d;
      end
   end

   assign product = prod_q;

endmodule
`default_nettype wire

// File: rtl/fp_mul_iter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fp_mul_iter : iterative IEEE-754-style multiplier, RNE, flush-to-zero|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module fp_mul_iter
   import fp_pkg::*;
#(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start_sig,
   input  logic [EXP_W+MAN_W:0]   A,
   input  logic [EXP_W+MAN_W:0]   B,
   output logic                   busy,
   output logic                   done_sig,
   output logic [EXP_W+MAN_W:0]   result,
   output logic [3:0]             flags
);

   localparam int W     = 1 + EXP_W + MAN_W;
   localparam int M     = MAN_W + 1;
   localparam int PW    = 2 * M;
   localparam int EW    = EXP_W + 2;
   localparam int CNT_W = $clog2(MAN_W + 2);
   localparam int BIAS  = fp_bias(EXP_W);
   localparam logic [63:0]   QNAN64  = fp_qnan(EXP_W, MAN_W);
   localparam logic [W-1:0]  QNAN    = QNAN64[W-1:0];
   localparam logic [EW-1:0] BIAS_E  = BIAS[EW-1:0];
   localparam logic [EW-1:0] EXP_MAX = {2'b00, {EXP_W{1'b1}}};

   fp_state_t        state_q, state_d;
   logic [W-1:0]     a_q, a_d, b_q, b_d;
   logic             sign_q, sign_d;
   logic [EW-1:0]    exp_q, exp_d;
   logic             spec_q, spec_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [PW-1:0]    nrm_q, nrm_d;
   logic             lost_q, lost_d;
   logic [W-1:0]     pend_res_q, pend_res_d;
   logic [3:0]       pend_flg_q, pend_flg_d;
   logic             busy_q, busy_d, done_q, done_d;
   logic [W-1:0]     result_q, result_d;
   logic [3:0]       flags_q, flags_d;

   logic [EXP_W-1:0] w_ea, w_eb;
   logic [MAN_W-1:0] w_fa, w_fb;
   logic             w_sign;
   logic             w_a_zero, w_a_inf, w_a_nan, w_a_snan;
   logic             w_b_zero, w_b_inf, w_b_nan, w_b_snan;
   logic             w_mul_load, w_mul_step;
   logic [PW-1:0]    w_prod;
   logic [MAN_W-1:0] w_frac;
   logic             w_guard, w_sticky, w_rup, w_inexact, w_ovf, w_unf;
   logic [MAN_W:0]   w_frac_r;
   logic [EW-1:0]    w_exp_r;

   assign w_ea     = a_q[W-2:MAN_W];
   assign w_eb     = b_q[W-2:MAN_W];
   assign w_fa     = a_q[MAN_W-1:0];
   assign w_fb     = b_q[MAN_W-1:0];
   assign w_sign   = a_q[W-1] ^ b_q[W-1];
   assign w_a_zero = (w_ea == '0);
   assign w_b_zero = (w_eb == '0);
   assign w_a_inf  = (&w_ea) && (w_fa == '0);
   assign w_b_inf  = (&w_eb) && (w_fb == '0);
   assign w_a_nan  = (&w_ea) && (w_fa != '0);
   assign w_b_nan  = (&w_eb) && (w_fb != '0);
   assign w_a_snan = w_a_nan && !w_fa[MAN_W-1];
   assign w_b_snan = w_b_nan && !w_fb[MAN_W-1];

   assign w_mul_load = (state_q == ST_UNPACK);
   assign w_mul_step = (state_q == ST_MUL);

   fp_mant_mul_seq #(.MAN_W(MAN_W)) u_mant_mul (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (w_mul_load),
      .step    (w_mul_step),
      .mcand   ({1'b1, w_fa}),
      .mplier  ({1'b1, w_fb}),
      .product (w_prod)
   );

   // After NORM the hidden one sits at bit PW-2; the shifted-out bit joins sticky.
   assign w_frac    = nrm_q[PW-3:M-1];
   assign w_guard   = nrm_q[M-2];
   assign w_sticky  = lost_q | (|nrm_q[M-3:0]);
   assign w_rup     = w_guard & (w_sticky | w_frac[0]);
   assign w_frac_r  = {1'b0, w_frac} + {{MAN_W{1'b0}}, w_rup};
   assign w_exp_r   = exp_q + {{(EW-1){1'b0}}, w_frac_r[MAN_W]};
   assign w_inexact = w_guard | w_sticky;
   assign w_ovf     = !w_exp_r[EW-1] && (w_exp_r >= EXP_MAX);
   assign w_unf     = w_exp_r[EW-1] || (w_exp_r == '0);

   always_comb begin
      state_d    = state_q;
      a_d        = a_q;
      b_d        = b_q;
      sign_d     = sign_q;
      exp_d      = exp_q;
      spec_d     = spec_q;
      cnt_d      = cnt_q;
      nrm_d      = nrm_q;
      lost_d     = lost_q;
      pend_res_d = pend_res_q;
      pend_flg_d = pend_flg_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      result_d   = result_q;
      flags_d    = flags_q;
      case (state_q)
         ST_IDLE: begin
            if (start_sig) begin
               a_d     = A;
               b_d     = B;
               busy_d  = 1'b1;
               state_d = ST_UNPACK;
            end
         end
         ST_UNPACK: begin
            sign_d     = w_sign;
            exp_d      = {2'b00, w_ea} + {2'b00, w_eb} - BIAS_E;
            cnt_d      = '0;
            spec_d     = 1'b1;
            pend_flg_d = '0;
            if (w_a_nan || w_b_nan) begin
               pend_res_d              = QNAN;
               pend_flg_d[FLG_INVALID] = w_a_snan | w_b_snan;
            end else if ((w_a_inf && w_b_zero) || (w_b_inf && w_a_zero)) begin
               pend_res_d              = QNAN;
               pend_flg_d[FLG_INVALID] = 1'b1;
            end else if (w_a_inf || w_b_inf) begin
               pend_res_d = {w_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            end else if (w_a_zero || w_b_zero) begin
               pend_res_d = {w_sign, {(W-1){1'b0}}};
            end else begin
               spec_d     = 1'b0;
            end
            state_d = ST_MUL;
         end
         ST_MUL: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(MAN_W)) begin
               state_d = ST_NORM;
            end
         end
         ST_NORM: begin
            if (w_prod[PW-1]) begin
               nrm_d  = {1'b0, w_prod[PW-1:1]};
               lost_d = w_prod[0];
               exp_d  = exp_q + EW'(1);
            end else begin
               nrm_d  = w_prod;
               lost_d = 1'b0;
            end
            state_d = ST_ROUND;
         end
         ST_ROUND: begin
            if (!spec_q) begin
               pend_flg_d = '0;
               if (w_ovf) begin
                  pend_res_d                = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                  pend_flg_d[FLG_OVERFLOW]  = 1'b1;
                  pend_flg_d[FLG_INEXACT]   = 1'b1;
               end else if (w_unf) begin
                  pend_res_d                = {sign_q, {(W-1){1'b0}}};
                  pend_flg_d[FLG_UNDERFLOW] = 1'b1;
                  pend_flg_d[FLG_INEXACT]   = 1'b1;
               end else begin
                  pend_res_d                = {sign_q, w_exp_r[EXP_W-1:0], w_frac_r[MAN_W-1:0]};
                  pend_flg_d[FLG_INEXACT]   = w_inexact;
               end
            end
            state_d = ST_DONE;
         end
         ST_DONE: begin
            result_d = pend_res_q;
            flags_d  = pend_flg_q;
            done_d   = 1'b1;
            busy_d   = 1'b0;
            state_d  = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         a_q        <= '0;
         b_q        <= '0;
         sign_q     <= 1'b0;
         exp_q      <= '0;
         spec_q     <= 1'b0;
         cnt_q      <= '0;
         nrm_q      <= '0;
         lost_q     <= 1'b0;
         pend_res_q <= '0;
         pend_flg_q <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         result_q   <= '0;
         flags_q    <= '0;
      end else begin
         state_q    <= state_d;
         a_q        <= a_d;
         b_q        <= b_d;
         sign_q     <= sign_d;
         exp_q      <= exp_d;
         spec_q     <= spec_d;
         cnt_q      <= cnt_d;
         nrm_q      <= nrm_d;
         lost_q     <= lost_d;
         pend_res_q <= pend_res_d;
         pend_flg_q <= pend_flg_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         result_q   <= result_d;
         flags_q    <= flags_d;
      end
   end

   assign busy     = busy_q;
   assign done_sig = done_q;
   assign result   = result_q;
   assign flags    = flags_q;

endmodule
`default_nettype wire

// File: tb/tb_fp_mul_iter.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_fp_mul_iter : vector table, randomised model comparison, corners  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_fp_mul_iter;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic [3:0]  flg;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start_sig = 1'b0;
   logic [31:0] A = '0, B = '0;
   logic        busy, done_sig;
   logic [31:0] result;
   logic [3:0]  flags;

   logic        h_start = 1'b0;
   logic [15:0] h_A = '0, h_B = '0;
   logic        h_busy, h_done;
   logic [15:0] h_result;
   logic [3:0]  h_flags;

   int   checks = 0;
   int   failures = 0;
   vec_t vt[$];

   always #5 clk = ~clk;

   fp_mul_iter dut (
      .clk(clk), .rst_n(rst_n), .start_sig(start_sig), .A(A), .B(B),
      .busy(busy), .done_sig(done_sig), .result(result), .flags(flags)
   );

   fp_mul_iter #(.EXP_W(5), .MAN_W(10)) dut_h (
      .clk(clk), .rst_n(rst_n), .start_sig(h_start), .A(h_A), .B(h_B),
      .busy(h_busy), .done_sig(h_done), .result(h_result), .flags(h_flags)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   // Reference: exact integer product, then round-to-nearest-even by remainder.
   function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] r, output logic [3:0] f);
      int ea, eb, e, sh;
      longint unsigned ma, mb, p, q, rem, half;
      logic s, az, bz, ai, bi, an, bn, asn, bsn;
      ea  = int'(a[30:23]);
      eb  = int'(b[30:23]);
      s   = a[31] ^ b[31];
      az  = (ea == 0);
      bz  = (eb == 0);
      ai  = (ea == 255) && (a[22:0] == 0);
      bi  = (eb == 255) && (b[22:0] == 0);
      an  = (ea == 255) && (a[22:0] != 0);
      bn  = (eb == 255) && (b[22:0] != 0);
      asn = an && !a[22];
      bsn = bn && !b[22];
      f   = 4'b0000;
      r   = '0;
      if (an || bn) begin
         r    = 32'h7FC00000;
         f[3] = asn || bsn;
      end else if ((ai && bz) || (bi && az)) begin
         r = 32'h7FC00000;
         f = 4'b1000;
      end else if (ai || bi) begin
         r = {s, 8'hFF, 23'h0};
      end else if (az || bz) begin
         r = {s, 31'h0};
      end else begin
         ma = {40'd0, 1'b1, a[22:0]};
         mb = {40'd0, 1'b1, b[22:0]};
         p  = ma * mb;
         e  = ea + eb - 127;
         sh = 23;
         if (p >= (64'd1 << 47)) begin
            sh = 24;
            e  = e + 1;
         end
         q    = p >> sh;
         rem  = p - (q << sh);
         half = 64'd1 << (sh - 1);
         if (rem > half || (rem == half && q[0])) q = q + 1;
         if (q == (64'd1 << 24)) begin
            q = q >> 1;
            e = e + 1;
         end
         if (e >= 255) begin
            r = {s, 8'hFF, 23'h0};
            f = 4'b0101;
         end else if (e <= 0) begin
            r = {s, 31'h0};
            f = 4'b0011;
         end else begin
            r = {s, 8'(e), q[22:0]};
            f = {3'b000, rem != 0};
         end
      end
   endfunction

   function automatic logic [31:0] rand_op();
      logic [31:0] v;
      int sel;
      v   = $urandom;
      sel = int'($urandom_range(0, 15));
      case (sel)
         0:       v[30:23] = 8'h00;
         1:       v[30:23] = 8'hFF;
         2:       begin v[30:23] = 8'hFF; v[22:0] = '0; end
         3:       v[30:23] = 8'($urandom_range(1, 8));
         4:       v[30:23] = 8'($urandom_range(240, 254));
         default: v[30:23] = 8'($urandom_range(64, 190));
      endcase
      return v;
   endfunction

   task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] r, output logic [3:0] f,
                         output int lat, output logic bsy);
      @(negedge clk);
      A = a;
      B = b;
      start_sig = 1'b1;
      @(posedge clk);
      #1;
      start_sig = 1'b0;
      bsy = busy;
      lat = -1;
      r   = 'x;
      f   = 'x;
      for (int i = 1; i <= 60; i++) begin
         @(posedge clk);
         #1;
         if (done_sig) begin
            lat = i;
            r   = result;
            f   = flags;
            break;
         end
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
      $fatal(1);
   end

   initial begin
      logic [31:0] r, er;
      logic [3:0]  f, ef;
      logic [15:0] hr;
      logic [3:0]  hf;
      logic        bsy;
      int          lat, ndone;

      vt.push_back('{32'h3FC00000, 32'h40000000, 32'h40400000, 4'b0000});
      vt.push_back('{32'h3F800800, 32'h3F800800, 32'h3F801000, 4'b0001});
      vt.push_back('{32'h7F000000, 32'h7F000000, 32'h7F800000, 4'b0101});
      vt.push_back('{32'h00800000, 32'h00800000, 32'h00000000, 4'b0011});
      vt.push_back('{32'h7F800000, 32'h80000000, 32'h7FC00000, 4'b1000});
      vt.push_back('{32'h7FC00000, 32'h3F800000, 32'h7FC00000, 4'b0000});
      vt.push_back('{32'h7F800001, 32'h3F800000, 32'h7FC00000, 4'b1000});
      vt.push_back('{32'hFF800000, 32'h40000000, 32'hFF800000, 4'b0000});
      vt.push_back('{32'h80000000, 32'h40400000, 32'h80000000, 4'b0000});
      vt.push_back('{32'h80000001, 32'h3F800000, 32'h80000000, 4'b0000});
      vt.push_back('{32'h3F800001, 32'h3F800001, 32'h3F800002, 4'b0001});
      vt.push_back('{32'h3FFFFFFF, 32'h3FFFFFFF, 32'h407FFFFE, 4'b0001});
      vt.push_back('{32'h3F7FFFFF, 32'h3F800001, 32'h3F800000, 4'b0001});
      vt.push_back('{32'h7F000000, 32'h3F800000, 32'h7F000000, 4'b0000});
      vt.push_back('{32'h00800000, 32'h3F800000, 32'h00800000, 4'b0000});
      vt.push_back('{32'h00800000, 32'h3F000000, 32'h00000000, 4'b0011});

      #12;
      chk("reset busy", busy, 0);
      chk("reset done_sig", done_sig, 0);
      chk("reset result", result, 0);
      chk("reset flags", flags, 0);
      @(negedge clk);
      rst_n = 1'b1;

      foreach (vt[i]) begin
         run_op(vt[i].a, vt[i].b, r, f, lat, bsy);
         chk($sformatf("vec%0d result", i), r, vt[i].res);
         chk($sformatf("vec%0d flags", i), f, vt[i].flg);
         chk($sformatf("vec%0d latency", i), lat, 28);
         if (i == 0) chk("busy after accept", bsy, 1);
      end
      chk("busy after done", busy, 0);

      for (int k = 0; k < 40; k++) begin
         logic [31:0] ra, rb;
         ra = rand_op();
         rb = rand_op();
         model(ra, rb, er, ef);
         run_op(ra, rb, r, f, lat, bsy);
         chk($sformatf("rand%0d %h*%h result", k, ra, rb), r, er);
         chk($sformatf("rand%0d %h*%h flags", k, ra, rb), f, ef);
      end

      @(negedge clk);
      A = 32'h3FC00000;
      B = 32'h40000000;
      start_sig = 1'b1;
      @(posedge clk);
      #1;
      start_sig = 1'b0;
      lat = -1;
      r = 'x;
      f = 'x;
      for (int i = 1; i <= 60; i++) begin
         @(negedge clk);
         start_sig = (i == 10);
         if (i == 10) begin
            A = 32'h7F000000;
            B = 32'h7F000000;
         end
         @(posedge clk);
         #1;
         if (done_sig) begin
            lat = i;
            r = result;
            f = flags;
            break;
         end
      end
      start_sig = 1'b0;
      chk("repulse latency", lat, 28);
      chk("repulse result", r, 32'h40400000);
      chk("repulse flags", f, 0);
      ndone = 0;
      for (int i = 0; i < 35; i++) begin
         @(posedge clk);
         #1;
         if (done_sig) ndone++;
      end
      chk("repulse not queued", ndone, 0);

      @(negedge clk);
      A = 32'h3F800800;
      B = 32'h3F800800;
      start_sig = 1'b1;
      @(posedge clk);
      #1;
      start_sig = 1'b0;
      repeat (14) @(posedge clk);
      @(posedge clk);
      #1;
      chk("busy before reset", busy, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midop reset busy", busy, 0);
      chk("midop reset done_sig", done_sig, 0);
      chk("midop reset result", result, 0);
      chk("midop reset flags", flags, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      ndone = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         if (done_sig) ndone++;
      end
      chk("no done after reset", ndone, 0);
      chk("result held zero", result, 0);

      run_op(32'h3FC00000, 32'h40000000, r, f, lat, bsy);
      chk("post-reset result", r, 32'h40400000);
      chk("post-reset latency", lat, 28);

      @(negedge clk);
      h_A = 16'h3C00;
      h_B = 16'hC000;
      h_start = 1'b1;
      @(posedge clk);
      #1;
      h_start = 1'b0;
      lat = -1;
      hr = 'x;
      hf = 'x;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk);
         #1;
         if (h_done) begin
            lat = i;
            hr = h_result;
            hf = h_flags;
            break;
         end
      end
      chk("half result", hr, 16'hC000);
      chk("half flags", hf, 0);
      chk("half latency", lat, 15);

      @(negedge clk);
      h_A = 16'h3E00;
      h_B = 16'h4000;
      h_start = 1'b1;
      @(posedge clk);
      #1;
      h_start = 1'b0;
      hr = 'x;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk);
         #1;
         if (h_done) begin
            hr = h_result;
            break;
         end
      end
      chk("half 1.5*2 result", hr, 16'h4200);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/fp_mul_iter.md
FP_MUL_ITER -- requirements
Module: fp_mul_iter

Interface
REQ-001 SHALL have parameter EXP_W, default 8, exponent field width (>=3).
REQ-002 SHALL have parameter MAN_W, default 23, stored mantissa fraction width (>=2); W = 1+EXP_W+MAN_W.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port start_sig  input  1  request; sampled only in IDLE.
REQ-006 SHALL have port A  input  W  operand, IEEE-754-style {sign,exp,frac}.
REQ-007 SHALL have port B  input  W  operand, same format.
REQ-008 SHALL have port busy  output  1  high from the cycle after accept until done.
REQ-009 SHALL have port done_sig  output  1  one-cycle completion pulse.
REQ-010 SHALL have port result  output  W  product, held until the next done_sig.
REQ-011 SHALL have port flags  output  4  {invalid,overflow,underflow,inexact}, updated with result.

Function
REQ-012 SHALL use FSM IDLE -> UNPACK -> MUL -> NORM -> ROUND -> DONE -> IDLE.
REQ-013 SHALL capture A and B on the edge where start_sig=1 in IDLE; later input changes are ignored.
REQ-014 SHALL ignore start_sig in every state except IDLE; no queuing.
REQ-015 SHALL in UNPACK compute sign XOR, biased exponent sum ea+eb-BIAS (BIAS=2^(EXP_W-1)-1) in EXP_W+2-bit signed, and classify zero/inf/NaN.
REQ-016 SHALL treat exp=0 inputs (zero or subnormal) as signed zero (flush-to-zero).
REQ-017 SHALL form the 2*(MAN_W+1)-bit significand product by radix-2 shift-add, one multiplier bit per cycle, exactly MAN_W+1 MUL cycles.
REQ-018 SHALL in NORM shift right one place and increment the exponent if product MSB is set; no other normalisation is needed.
REQ-019 SHALL in ROUND round to nearest, ties to even, using guard bit and OR of all lower bits as sticky; mantissa carry-out SHALL increment the exponent.
REQ-020 SHALL set inexact when guard or sticky is 1 on a finite normal result.
REQ-021 SHALL on final exponent >= 2^EXP_W-1 return signed infinity, set overflow and inexact.
REQ-022 SHALL on final exponent <= 0 return signed zero, set underflow and inexact (zero operands excluded).
REQ-023 SHALL on any NaN operand, or inf times zero, return canonical NaN {0, all-ones exp, frac MSB=1, rest 0}; invalid SHALL be set only for signalling NaN input or inf*0.
REQ-024 SHALL return signed infinity for inf*finite-nonzero and signed zero for zero*finite, flags all 0.
REQ-025 SHALL take fixed latency: done_sig high exactly MAN_W+5 cycles after the accept edge (28 for defaults), special cases included.
REQ-026 SHALL update result and flags on the same edge that raises done_sig; busy falls on that edge; a new start_sig is accepted on the next cycle.

Reset
REQ-027 SHALL, on rst_n low at any time, mid-operation included, abort, enter IDLE, clear busy, done_sig, result, flags to 0 and drop the operation in flight.
REQ-028 SHALL accept no start_sig before the first rising clk edge after rst_n deasserts.

Structure
REQ-029 SHALL place FSM state encoding, flag bit indices and BIAS/QNAN helper functions of EXP_W, MAN_W in shared package fp_pkg.
REQ-030 SHALL implement the shift-add datapath as sub-module fp_mant_mul_seq (parameter MAN_W; load, step, product); unpack, normalise and round stay in fp_mul_iter.

Verification
REQ-031 SHALL cover: A=0x3FC00000, B=0x40000000 -> result 0x40400000, flags 0000, done_sig at cycle 28.
REQ-032 SHALL cover: A=B=0x3F800800 -> result 0x3F801000 (tie to even), flags 0001.
REQ-033 SHALL cover: A=B=0x7F000000 -> 0x7F800000, flags 0101; A=B=0x00800000 -> 0x00000000, flags 0011.
REQ-034 SHALL cover: A=0x7F800000, B=0x80000000 -> 0x7FC00000, flags 1000; A=0x7FC00000, B=0x3F800000 -> 0x7FC00000, flags 0000.
REQ-035 SHALL cover: start_sig re-pulsed with new operands at cycle 10 -> ignored, first result unchanged; rst_n low at cycle 15 -> all outputs 0, no done_sig.
REQ-036 SHALL cover: EXP_W=5, MAN_W=10, A=0x3C00, B=0xC000 -> 0xC000, done_sig at cycle 15.
